cache_store_buffer: RTL and testbench

//   FIFO store buffer upstream of the cache way write stage. Accepts CPU store

---
 rtl/cache_store_buffer.sv | 99 +++++++++
 tb/tb_cache_store_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_store_buffer.sv
// Store buffer in front of the cache way write stage.
// CPU stores (one-hot hit way + data) are queued in a small circular FIFO.
// At most one store drains per cycle onto a registered targetWay/data pair.
// A targetWay of zero means no write this cycle.
// A store whose way vector is zero or multi-hot still completes its handshake.
// Such a store is dropped, and errPulse is raised for one cycle.
module cache_store_buffer #(
  parameter int NUM_WAYS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       storeValid,
  output logic                       storeReady,
  input  logic [NUM_WAYS-1:0]        storeWay,
  input  logic [DATA_WIDTH-1:0]      storeData,
  input  logic                       stall,
  output logic [NUM_WAYS-1:0]        targetWay,
  output logic [DATA_WIDTH-1:0]      data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       errPulse
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_WAYS-1:0]   way_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic push_hs;
  logic way_ok;
  logic do_push;
  logic do_pop;

  // Status flags come straight from the registered occupancy.
  // Because of this, a pop cannot free a slot for a push in the same cycle.
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign storeReady = !full;
  assign count      = count_q;

  assign push_hs = storeValid && storeReady;
  assign way_ok  = $onehot(storeWay);
  assign do_push = push_hs && way_ok;
  assign do_pop  = !stall && !empty;

  // Entry storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      way_mem[wr_ptr]  <= storeWay;
      data_mem[wr_ptr] <= storeData;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered drain port; zero whenever no entry is popped.
  always_ff @(posedge clk) begin
    if (rst || !do_pop) begin
      targetWay <= '0;
      data      <= '0;
    end else begin
      targetWay <= way_mem[rd_ptr];
      data      <= data_mem[rd_ptr];
    end
  end

  // One-cycle flag for an accepted store with a malformed way vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      errPulse <= 1'b0;
    end else begin
      errPulse <= push_hs && !way_ok;
    end
  end

endmodule

// File: tb/tb_cache_store_buffer.sv
// Directed and random checks of cache_store_buffer against a queue-based reference model.
module tb_cache_store_buffer;

  localparam int NW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          storeValid;
  logic          storeReady;
  logic [NW-1:0] storeWay;
  logic [DW-1:0] storeData;
  logic          stall;
  logic [NW-1:0] targetWay;
  logic [DW-1:0] data;
  logic [2:0]    count;
  logic          empty;
  logic          full;
  logic          errPulse;

  cache_store_buffer #(.NUM_WAYS(NW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .storeValid (storeValid),
    .storeReady (storeReady),
    .storeWay   (storeWay),
    .storeData  (storeData),
    .stall      (stall),
    .targetWay  (targetWay),
    .data       (data),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .errPulse   (errPulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NW-1:0] w;
    logic [DW-1:0] d;
  } ent_t;

  typedef struct {
    logic [NW-1:0] w;
    logic [DW-1:0] d;
    int            cyc;
  } wr_t;

  ent_t          model_q[$];
  wr_t           got[$];
  logic [NW-1:0] exp_tw;
  logic [DW-1:0] exp_d;
  logic          exp_err;
  int            errors = 0;
  int            checks = 0;
  int            cyc_n  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the buffer is a plain queue of at most DEPTH stores.
  task automatic model_step();
    ent_t e;
    bit   ready;
    bit   acc;
    bit   good;
    if (rst) begin
      model_q.delete();
      exp_tw  = '0;
      exp_d   = '0;
      exp_err = 1'b0;
    end else begin
      ready = model_q.size() < DEPTH;
      acc   = storeValid && ready;
      good  = $countones(storeWay) == 1;
      if (!stall && model_q.size() > 0) begin
        e      = model_q.pop_front();
        exp_tw = e.w;
        exp_d  = e.d;
      end else begin
        exp_tw = '0;
        exp_d  = '0;
      end
      exp_err = acc && !good;
      if (acc && good) begin
        e.w = storeWay;
        e.d = storeData;
        model_q.push_back(e);
      end
    end
  endtask

  task automatic check_all();
    int n;
    n = model_q.size();
    check("targetWay",  64'(targetWay),  64'(exp_tw));
    check("data",       64'(data),       64'(exp_d));
    check("errPulse",   64'(errPulse),   64'(exp_err));
    check("count",      64'(count),      64'(n));
    check("empty",      64'(empty),      64'(n == 0));
    check("full",       64'(full),       64'(n == DEPTH));
    check("storeReady", 64'(storeReady), 64'(n < DEPTH));
    if (targetWay != '0) got.push_back('{targetWay, data, cyc_n});
  endtask

  // One clock: drive inputs, update model at the edge, check at the falling edge.
  task automatic cyc(input logic v, input logic [NW-1:0] w, input logic [DW-1:0] d,
                     input logic s, input logic r);
    storeValid = v;
    storeWay   = w;
    storeData  = d;
    stall      = s;
    rst        = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc_n++;
    check_all();
  endtask

  task automatic idle(input int n, input logic s);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, s, 1'b0);
  endtask

  logic [NW-1:0] ways4 [4];
  int            push_cyc;
  logic [NW-1:0] rw;
  int            sel;

  initial begin
    ways4[0] = 4'b0001; ways4[1] = 4'b0010; ways4[2] = 4'b0100; ways4[3] = 4'b1000;
    storeValid = 1'b0; storeWay = '0; storeData = '0; stall = 1'b0; rst = 1'b1;
    @(negedge clk);

    // Reset held for two cycles.
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check("rst_targetWay", 64'(targetWay), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    idle(1, 1'b0);

    // Single store: written two cycles after storeValid, for exactly one cycle.
    got.delete();
    push_cyc = cyc_n + 1;
    cyc(1'b1, 4'b0100, 32'hDEADBEEF, 1'b0, 1'b0);
    idle(4, 1'b0);
    check("single_nwrites", 64'(got.size()), 64'd1);
    if (got.size() == 1) begin
      check("single_latency", 64'(got[0].cyc), 64'(push_cyc + 1));
      check("single_data", 64'(got[0].d), 64'hDEADBEEF);
    end

    // Fill under stall, then drain in push order.
    got.delete();
    for (int i = 0; i < 4; i++) cyc(1'b1, ways4[i], 32'(i + 1), 1'b1, 1'b0);
    check("fill_full", 64'(full), 64'd1);
    check("fill_ready", 64'(storeReady), 64'd0);
    cyc(1'b1, 4'b0001, 32'h99, 1'b1, 1'b0);
    idle(6, 1'b0);
    check("fill_nwrites", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      check("fill_order_way", 64'(got[i].w), 64'(ways4[i]));
      check("fill_order_data", 64'(got[i].d), 64'(i + 1));
    end

    // Three entries, stall for two cycles mid-drain.
    got.delete();
    for (int i = 0; i < 3; i++) cyc(1'b1, ways4[3 - i], 32'h100 + 32'(i), 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);
    idle(4, 1'b0);
    check("stall_nwrites", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3 && i < got.size(); i++)
      check("stall_order", 64'(got[i].d), 64'h100 + 64'(i));

    // Malformed way vectors: error pulse, nothing queued, nothing written.
    got.delete();
    cyc(1'b1, 4'b0011, 32'h55, 1'b0, 1'b0);
    check("err_multi", 64'(errPulse), 64'd1);
    cyc(1'b1, 4'b0000, 32'h66, 1'b0, 1'b0);
    check("err_zero", 64'(errPulse), 64'd1);
    idle(3, 1'b0);
    check("err_nwrites", 64'(got.size()), 64'd0);

    // Reset while draining discards the remaining entries.
    got.delete();
    for (int i = 0; i < 3; i++) cyc(1'b1, ways4[i], 32'h200 + 32'(i), 1'b1, 1'b0);
    idle(1, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check("rstmid_targetWay", 64'(targetWay), 64'd0);
    check("rstmid_count", 64'(count), 64'd0);
    idle(5, 1'b0);
    check("rstmid_nwrites", 64'(got.size()), 64'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      rw = '0;
      else if (sel == 1) rw = 4'($urandom);
      else               rw = ways4[$urandom_range(0, 3)];
      cyc($urandom_range(0, 9) < 7, rw, $urandom, $urandom_range(0, 9) < 3,
          $urandom_range(0, 99) < 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
